// File: rtl/reg_file_sb_if.sv
// Command, response and writeback signals of the scoreboarded register file.
// The master side issues commands and writebacks; the slave side is the register file.
interface reg_file_sb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 6
);
    logic                  i_valid;
    logic                  o_ready;
    logic [2:0]            i_cmd;
    logic [REG_AW-1:0]     i_reg;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_res_valid;
    logic                  i_res_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_res_err;
    logic                  i_wb_valid;
    logic [REG_AW-1:0]     i_wb_reg;
    logic [DATA_WIDTH-1:0] i_wb_data;

    modport master (
        output i_valid, i_cmd, i_reg, i_data, i_res_ready,
        output i_wb_valid, i_wb_reg, i_wb_data,
        input  o_ready, o_res_valid, o_data, o_res_err
    );

    modport slave (
        input  i_valid, i_cmd, i_reg, i_data, i_res_ready,
        input  i_wb_valid, i_wb_reg, i_wb_data,
        output o_ready, o_res_valid, o_data, o_res_err
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with per-register saturating pending-writer counters, one
// handshaked command port and an always-accepted writeback port.
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int REG_AW     = 6,
    parameter int PEND_W     = 2
) (
    input logic          clk,
    input logic          reset,
    reg_file_sb_if.slave bus
);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    typedef enum logic [2:0] {
        CMD_READ      = 3'd0,
        CMD_WRITE     = 3'd1,
        CMD_MARKD     = 3'd2,
        CMD_CHECK     = 3'd3,
        CMD_READ_WAIT = 3'd4,
        CMD_FLUSH     = 3'd5
    } cmd_e;

    state_e                state, state_n;
    logic [DATA_WIDTH-1:0] regs   [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_n [NUM_REGS];
    logic [PEND_W-1:0]     pend   [NUM_REGS];
    logic [PEND_W-1:0]     pend_n [NUM_REGS];
    logic [REG_AW-1:0]     wait_reg, wait_reg_n;
    logic [DATA_WIDTH-1:0] resp_data, resp_data_n;
    logic                  resp_err, resp_err_n;

    logic                  accept, cmd_legal, flush_hit;
    logic                  wb_hit, wr_hit, mk_hit;
    logic [PEND_W:0]       pend_sum, pend_dec;
    logic [DATA_WIDTH-1:0] sel_data, wait_data;
    logic [PEND_W-1:0]     sel_pend, wait_pend;

    always_comb begin
        accept    = bus.i_valid && (state == IDLE);
        cmd_legal = (bus.i_cmd <= CMD_FLUSH) && (32'(bus.i_reg) < NUM_REGS);
        flush_hit = accept && cmd_legal && (bus.i_cmd == CMD_FLUSH);
        sel_data  = '0;
        sel_pend  = '0;
        wait_data = '0;
        wait_pend = '0;
        wb_hit    = 1'b0;
        wr_hit    = 1'b0;
        mk_hit    = 1'b0;
        pend_sum  = '0;
        pend_dec  = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (bus.i_reg == REG_AW'(i)) begin
                sel_data = regs[i];
                sel_pend = pend[i];
            end
            if (wait_reg == REG_AW'(i)) begin
                wait_data = regs[i];
                wait_pend = pend[i];
            end

            wb_hit = bus.i_wb_valid && (bus.i_wb_reg == REG_AW'(i));
            wr_hit = accept && cmd_legal && (bus.i_cmd == CMD_WRITE) &&
                     (bus.i_reg == REG_AW'(i));
            mk_hit = accept && cmd_legal && (bus.i_cmd == CMD_MARKD) &&
                     (bus.i_reg == REG_AW'(i)) && (pend[i] != PEND_MAX);

            // Increment first, then subtract all retiring writers with a floor at 0,
            // so MARKD + writeback nets to zero and WRITE + writeback subtracts two.
            pend_sum = (PEND_W+1)'(pend[i]) + (PEND_W+1)'(mk_hit);
            pend_dec = (PEND_W+1)'(wb_hit) + (PEND_W+1)'(wr_hit);

            regs_n[i] = regs[i];
            if (wb_hit) regs_n[i] = bus.i_wb_data;
            if (wr_hit) regs_n[i] = bus.i_data;

            pend_n[i] = (pend_sum > pend_dec) ? PEND_W'(pend_sum - pend_dec) : '0;
            if (flush_hit) pend_n[i] = '0;
        end
    end

    always_comb begin
        state_n     = state;
        wait_reg_n  = wait_reg;
        resp_data_n = resp_data;
        resp_err_n  = resp_err;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n     = RESP;
                    wait_reg_n  = bus.i_reg;
                    resp_data_n = '0;
                    resp_err_n  = 1'b0;
                    if (!cmd_legal) begin
                        resp_err_n = 1'b1;
                    end else begin
                        case (bus.i_cmd)
                            CMD_READ:      resp_data_n = sel_data;
                            CMD_MARKD:     resp_err_n  = (sel_pend == PEND_MAX);
                            CMD_CHECK:     resp_data_n = DATA_WIDTH'(sel_pend);
                            CMD_READ_WAIT: begin
                                if (sel_pend != '0) state_n = WAIT;
                                else                resp_data_n = sel_data;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WAIT: begin
                if (wait_pend == '0) begin
                    state_n     = RESP;
                    resp_data_n = wait_data;
                end
            end
            RESP: begin
                if (bus.i_res_ready) begin
                    state_n     = IDLE;
                    resp_data_n = '0;
                    resp_err_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_reg  <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
                pend[i] <= '0;
            end
        end else begin
            state     <= state_n;
            wait_reg  <= wait_reg_n;
            resp_data <= resp_data_n;
            resp_err  <= resp_err_n;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= regs_n[i];
                pend[i] <= pend_n[i];
            end
        end
    end

    assign bus.o_ready     = (state == IDLE);
    assign bus.o_res_valid = (state == RESP);
    assign bus.o_data      = resp_data;
    assign bus.o_res_err   = resp_err;
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: stimulus queues expected responses,
// a monitor pops and compares at every response handshake.
module tb_reg_file_sb;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam int AW = 6;
    localparam int PW = 2;

    localparam logic [2:0] C_READ  = 3'd0;
    localparam logic [2:0] C_WRITE = 3'd1;
    localparam logic [2:0] C_MARKD = 3'd2;
    localparam logic [2:0] C_CHECK = 3'd3;
    localparam logic [2:0] C_RWAIT = 3'd4;
    localparam logic [2:0] C_FLUSH = 3'd5;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [DW:0] sb [$];
    logic [DW:0] mon_exp;

    reg_file_sb_if #(.DATA_WIDTH(DW), .REG_AW(AW)) bus ();

    reg_file_sb #(
        .DATA_WIDTH(DW),
        .NUM_REGS  (NR),
        .REG_AW    (AW),
        .PEND_W    (PW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.o_res_valid && bus.i_res_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got %h expected no response", bus.o_data);
            end else begin
                mon_exp = sb.pop_front();
                check("resp_data", bus.o_data, mon_exp[DW-1:0]);
                check("resp_err", 32'(bus.o_res_err), 32'(mon_exp[DW]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (!bus.o_ready && n < 50) begin
            step();
            n++;
        end
        check("idle_timeout", 32'(bus.o_ready), 32'd1);
    endtask

    task automatic issue(input logic [2:0] cmd, input logic [AW-1:0] r, input logic [DW-1:0] d,
                         input logic [DW-1:0] ed, input logic ee);
        wait_idle();
        bus.i_valid = 1'b1;
        bus.i_cmd   = cmd;
        bus.i_reg   = r;
        bus.i_data  = d;
        sb.push_back({ee, ed});
        step();
        bus.i_valid = 1'b0;
    endtask

    task automatic cmd_done(input logic [2:0] cmd, input logic [AW-1:0] r, input logic [DW-1:0] d,
                            input logic [DW-1:0] ed, input logic ee);
        issue(cmd, r, d, ed, ee);
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.o_ready), 32'd1);
        check({tag, "_valid"}, 32'(bus.o_res_valid), 32'd0);
        check({tag, "_data"}, bus.o_data, 32'd0);
        check({tag, "_err"}, 32'(bus.o_res_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_valid     = 1'b0;
        bus.i_cmd       = '0;
        bus.i_reg       = '0;
        bus.i_data      = '0;
        bus.i_res_ready = 1'b1;
        bus.i_wb_valid  = 1'b0;
        bus.i_wb_reg    = '0;
        bus.i_wb_data   = '0;
        repeat (2) step();
        check_reset_outputs("rst");
        reset = 1'b1;
        step();

        issue(C_READ, 6'd3, '0, 32'h0, 1'b0);
        check("t1_valid", 32'(bus.o_res_valid), 32'd1);
        check("t1_busy", 32'(bus.o_ready), 32'd0);
        step();
        check_reset_outputs("t1_after");

        cmd_done(C_WRITE, 6'd5, 32'hDEADBEEF, 32'h0, 1'b0);
        cmd_done(C_READ, 6'd5, '0, 32'hDEADBEEF, 1'b0);
        cmd_done(C_READ, 6'd8, '0, 32'h0, 1'b1);
        cmd_done(3'd7, 6'd0, '0, 32'h0, 1'b1);

        repeat (3) cmd_done(C_MARKD, 6'd2, '0, 32'h0, 1'b0);
        cmd_done(C_CHECK, 6'd2, '0, 32'd3, 1'b0);
        cmd_done(C_MARKD, 6'd2, '0, 32'h0, 1'b1);
        cmd_done(C_CHECK, 6'd2, '0, 32'd3, 1'b0);

        cmd_done(C_MARKD, 6'd1, '0, 32'h0, 1'b0);
        issue(C_RWAIT, 6'd1, '0, 32'h1234, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("wait_busy", 32'(bus.o_ready), 32'd0);
            check("wait_novalid", 32'(bus.o_res_valid), 32'd0);
            step();
        end
        bus.i_wb_valid = 1'b1;
        bus.i_wb_reg   = 6'd1;
        bus.i_wb_data  = 32'h1234;
        step();
        bus.i_wb_valid = 1'b0;
        check("wait_wb_edge", 32'(bus.o_res_valid), 32'd0);
        step();
        check("wait_resp_edge", 32'(bus.o_res_valid), 32'd1);
        wait_idle();

        repeat (2) cmd_done(C_MARKD, 6'd4, '0, 32'h0, 1'b0);
        wait_idle();
        bus.i_wb_valid = 1'b1;
        bus.i_wb_reg   = 6'd4;
        bus.i_wb_data  = 32'hB;
        issue(C_WRITE, 6'd4, 32'hA, 32'h0, 1'b0);
        bus.i_wb_valid = 1'b0;
        wait_idle();
        cmd_done(C_READ, 6'd4, '0, 32'hA, 1'b0);
        cmd_done(C_CHECK, 6'd4, '0, 32'd0, 1'b0);

        wait_idle();
        bus.i_wb_valid = 1'b1;
        bus.i_wb_reg   = 6'd7;
        bus.i_wb_data  = 32'h77;
        issue(C_MARKD, 6'd7, '0, 32'h0, 1'b0);
        bus.i_wb_valid = 1'b0;
        wait_idle();
        cmd_done(C_CHECK, 6'd7, '0, 32'd0, 1'b0);
        cmd_done(C_READ, 6'd7, '0, 32'h77, 1'b0);

        cmd_done(C_MARKD, 6'd3, '0, 32'h0, 1'b0);
        cmd_done(C_FLUSH, 6'd0, '0, 32'h0, 1'b0);
        cmd_done(C_CHECK, 6'd3, '0, 32'd0, 1'b0);
        cmd_done(C_CHECK, 6'd2, '0, 32'd0, 1'b0);

        bus.i_res_ready = 1'b0;
        issue(C_READ, 6'd5, '0, 32'hDEADBEEF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(bus.o_res_valid), 32'd1);
            check("hold_data", bus.o_data, 32'hDEADBEEF);
            check("hold_err", 32'(bus.o_res_err), 32'd0);
            check("hold_busy", 32'(bus.o_ready), 32'd0);
            step();
        end
        bus.i_res_ready = 1'b1;
        wait_idle();

        cmd_done(C_MARKD, 6'd6, '0, 32'h0, 1'b0);
        issue(C_RWAIT, 6'd6, '0, 32'h0, 1'b0);
        step();
        check("abort_in_wait", 32'(bus.o_ready), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        sb.delete();
        @(negedge clk);
        #1;
        reset = 1'b1;
        step();
        cmd_done(C_READ, 6'd5, '0, 32'h0, 1'b0);
        cmd_done(C_CHECK, 6'd6, '0, 32'd0, 1'b0);

        step();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
